// File: rtl/roce_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : roce_arb_pkg
// Description : Shared types and constants for the RoCE TX arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package roce_arb_pkg;

    localparam int c_MAX_REQ  = 8;
    localparam int c_REQ_ID_W = $clog2(c_MAX_REQ);
    localparam int c_STATS_W  = 32;

    typedef logic [c_REQ_ID_W-1:0] req_id_t;

    typedef enum logic [0:0] {
        META_EMPTY = 1'b0,
        META_HELD  = 1'b1
    } meta_state_t;

    // Pointer value that gives requester 0 first priority after reset.
    function automatic req_id_t rr_ptr_reset(input int n_req);
        return req_id_t'(n_req - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/roce_tx_order_fifo.sv
`default_nettype none
// ============================================================================
// Module      : roce_tx_order_fifo
// Description : Synchronous FIFO of requester ids, same-cycle push+pop allowed.
// Revision    : 1.0 - initial release
// ============================================================================
module roce_tx_order_fifo
    import roce_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  req_id_t i_push_id,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output req_id_t o_head
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_MAX = (c_PTR_W + 1)'(DEPTH);

    req_id_t              r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_full  = (r_count == c_CNT_MAX);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/roce_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : roce_tx_arbiter
// Description : Round-robin TX meta arbiter with in-order payload routing.
//               Optional per-requester counters: ROCE_TX_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module roce_tx_arbiter
    import roce_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int META_W      = 160,
    parameter int DATA_W      = 512,
    parameter int ORDER_DEPTH = 8
) (
    input  logic                      net_clk,
    input  logic                      net_rst,
    input  logic [N_REQ-1:0]          s_meta_valid,
    output logic [N_REQ-1:0]          s_meta_ready,
    input  logic [N_REQ*META_W-1:0]   s_meta_data,
    input  logic [N_REQ-1:0]          s_meta_payload,
    input  logic [N_REQ-1:0]          s_data_valid,
    output logic [N_REQ-1:0]          s_data_ready,
    input  logic [N_REQ-1:0]          s_data_last,
    input  logic [N_REQ*DATA_W-1:0]   s_data_data,
    input  logic [N_REQ*DATA_W/8-1:0] s_data_keep,
    output logic                      m_meta_valid,
    input  logic                      m_meta_ready,
    output logic [META_W-1:0]         m_meta_data,
    output logic                      m_data_valid,
    input  logic                      m_data_ready,
    output logic [DATA_W-1:0]         m_data_data,
    output logic [DATA_W/8-1:0]       m_data_keep,
    output logic                      m_data_last,
    output logic                      order_full
`ifdef ROCE_TX_ARB_STATS_EN
    ,
    output logic [N_REQ*c_STATS_W-1:0] stat_pkt_count,
    output logic [N_REQ*c_STATS_W-1:0] stat_cmd_count
`endif
);

    localparam int c_ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int c_KEEP_W = DATA_W / 8;

    meta_state_t          r_state;
    meta_state_t          w_state_nxt;
    logic [c_ID_W-1:0]    r_rr_ptr;
    logic [META_W-1:0]    r_meta_data;
    logic [c_ID_W-1:0]    w_idx;
    logic [c_ID_W-1:0]    w_pick;
    logic [c_ID_W-1:0]    w_head;
    logic                 w_found;
    logic                 w_arb_en;
    logic                 w_grant;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_route;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    req_id_t              w_fifo_head;

    logic [META_W-1:0]    w_req_meta [N_REQ];
    logic [DATA_W-1:0]    w_req_data [N_REQ];
    logic [c_KEEP_W-1:0]  w_req_keep [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_req_meta[gi] = s_meta_data[gi*META_W +: META_W];
            assign w_req_data[gi] = s_data_data[gi*DATA_W +: DATA_W];
            assign w_req_keep[gi] = s_data_keep[gi*c_KEEP_W +: c_KEEP_W];
        end
    endgenerate

    // Scan starts one past the last grant so every requester gets a turn.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = c_ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && s_meta_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_arb_en = (r_state == META_EMPTY) || m_meta_ready;
    assign w_grant  = !net_rst && w_arb_en && w_found
                      && !(s_meta_payload[w_pick] && w_fifo_full);
    assign w_push   = w_grant && s_meta_payload[w_pick];

    always_comb begin
        s_meta_ready = '0;
        if (w_grant) begin
            s_meta_ready[w_pick] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_grant) begin
            w_state_nxt = META_HELD;
        end else if (m_meta_ready) begin
            w_state_nxt = META_EMPTY;
        end
    end

    always_ff @(posedge net_clk) begin
        if (net_rst) begin
            r_state     <= META_EMPTY;
            r_rr_ptr    <= c_ID_W'(rr_ptr_reset(N_REQ));
            r_meta_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_meta_data <= w_req_meta[w_pick];
                r_rr_ptr    <= w_pick;
            end
        end
    end

    assign m_meta_valid = (r_state == META_HELD);
    assign m_meta_data  = r_meta_data;

    roce_tx_order_fifo #(
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (net_clk),
        .rst       (net_rst),
        .i_push    (w_push),
        .i_push_id (req_id_t'(w_pick)),
        .i_pop     (w_pop),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_head    (w_fifo_head)
    );

    // Payload follows the oldest outstanding payload command, combinationally.
    assign w_head       = c_ID_W'(w_fifo_head);
    assign w_route      = !net_rst && !w_fifo_empty;
    assign m_data_valid = w_route && s_data_valid[w_head];
    assign m_data_data  = w_req_data[w_head];
    assign m_data_keep  = w_req_keep[w_head];
    assign m_data_last  = s_data_last[w_head];
    assign w_pop        = m_data_valid && m_data_ready && m_data_last;
    assign order_full   = w_fifo_full;

    always_comb begin
        s_data_ready = '0;
        if (w_route) begin
            s_data_ready[w_head] = m_data_ready;
        end
    end

`ifdef ROCE_TX_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
            logic [c_STATS_W-1:0] r_pkt_cnt;
            logic [c_STATS_W-1:0] r_cmd_cnt;

            always_ff @(posedge net_clk) begin
                if (net_rst) begin
                    r_pkt_cnt <= '0;
                    r_cmd_cnt <= '0;
                end else begin
                    if (w_pop && (w_head == c_ID_W'(gi))) begin
                        r_pkt_cnt <= r_pkt_cnt + c_STATS_W'(1);
                    end
                    if (w_grant && (w_pick == c_ID_W'(gi))) begin
                        r_cmd_cnt <= r_cmd_cnt + c_STATS_W'(1);
                    end
                end
            end

            assign stat_pkt_count[gi*c_STATS_W +: c_STATS_W] = r_pkt_cnt;
            assign stat_cmd_count[gi*c_STATS_W +: c_STATS_W] = r_cmd_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_roce_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_roce_tx_arbiter
// Description : Randomized bench for roce_tx_arbiter against a queue-based
//               reference model; checks counters when ROCE_TX_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_roce_tx_arbiter;

    localparam int N     = 4;
    localparam int MW    = 16;
    localparam int DW    = 16;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    s_meta_valid, s_meta_ready, s_meta_payload;
    logic [N-1:0]    s_data_valid, s_data_ready, s_data_last;
    logic [N*MW-1:0] s_meta_data;
    logic [N*DW-1:0] s_data_data;
    logic [N*KW-1:0] s_data_keep;
    logic            m_meta_valid, m_meta_ready;
    logic [MW-1:0]   m_meta_data;
    logic            m_data_valid, m_data_ready, m_data_last;
    logic [DW-1:0]   m_data_data;
    logic [KW-1:0]   m_data_keep;
    logic            order_full;
`ifdef ROCE_TX_ARB_STATS_EN
    logic [N*32-1:0] stat_pkt_count, stat_cmd_count;
`endif

    roce_tx_arbiter #(
        .N_REQ(N), .META_W(MW), .DATA_W(DW), .ORDER_DEPTH(DEPTH)
    ) dut (
        .net_clk        (clk),
        .net_rst        (rst),
        .s_meta_valid   (s_meta_valid),
        .s_meta_ready   (s_meta_ready),
        .s_meta_data    (s_meta_data),
        .s_meta_payload (s_meta_payload),
        .s_data_valid   (s_data_valid),
        .s_data_ready   (s_data_ready),
        .s_data_last    (s_data_last),
        .s_data_data    (s_data_data),
        .s_data_keep    (s_data_keep),
        .m_meta_valid   (m_meta_valid),
        .m_meta_ready   (m_meta_ready),
        .m_meta_data    (m_meta_data),
        .m_data_valid   (m_data_valid),
        .m_data_ready   (m_data_ready),
        .m_data_data    (m_data_data),
        .m_data_keep    (m_data_keep),
        .m_data_last    (m_data_last),
        .order_full     (order_full)
`ifdef ROCE_TX_ARB_STATS_EN
        ,
        .stat_pkt_count (stat_pkt_count),
        .stat_cmd_count (stat_cmd_count)
`endif
    );

    typedef struct packed { logic pay; logic [MW-1:0] meta; } cmd_t;
    typedef struct packed { logic [DW-1:0] d; logic [KW-1:0] k; logic last; } beat_t;

    // Requester-side traffic still to be offered.
    cmd_t  cq [N][$];
    beat_t dq [N][$];

    // Reference model: last grant, output register, outstanding payload order.
    int            m_rr;
    bit            m_held;
    logic [MW-1:0] m_word;
    int            m_fifo [$];
    int            m_cmd_cnt [N];
    int            m_pkt_cnt [N];

    int       p_meta, p_data, p_mready, p_dready;
    logic [N-1:0] data_mask;
    int       seq, beats_seen;
    int       n_cmp = 0;
    int       n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic gen(input int r, input bit pay, input int nb);
        cmd_t  c;
        beat_t b;
        seq++;
        c.pay  = pay;
        c.meta = {4'(r), 12'(seq)};
        cq[r].push_back(c);
        if (pay) begin
            for (int j = 0; j < nb; j++) begin
                b.d    = {4'(r), 4'(j), 8'(seq)};
                b.k    = KW'($urandom);
                b.last = (j == nb - 1);
                dq[r].push_back(b);
            end
        end
    endtask

    function automatic bit idle();
        bit e = !m_held && (m_fifo.size() == 0);
        for (int i = 0; i < N; i++) begin
            if (cq[i].size() != 0 || dq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic model_reset();
        m_rr   = N - 1;
        m_held = 1'b0;
        m_word = '0;
        m_fifo.delete();
        for (int i = 0; i < N; i++) begin
            m_cmd_cnt[i] = 0;
            m_pkt_cnt[i] = 0;
            cq[i].delete();
            dq[i].delete();
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_meta_valid[i] = (cq[i].size() > 0) && ($urandom_range(99) < p_meta);
            if (cq[i].size() > 0) begin
                s_meta_payload[i]        = cq[i][0].pay;
                s_meta_data[i*MW +: MW]  = cq[i][0].meta;
            end else begin
                s_meta_payload[i]        = 1'($urandom);
                s_meta_data[i*MW +: MW]  = MW'($urandom);
            end
            s_data_valid[i] = data_mask[i] && (dq[i].size() > 0) && ($urandom_range(99) < p_data);
            if (dq[i].size() > 0) begin
                s_data_data[i*DW +: DW] = dq[i][0].d;
                s_data_keep[i*KW +: KW] = dq[i][0].k;
                s_data_last[i]          = dq[i][0].last;
            end else begin
                s_data_data[i*DW +: DW] = DW'($urandom);
                s_data_keep[i*KW +: KW] = KW'($urandom);
                s_data_last[i]          = 1'($urandom);
            end
        end
        m_meta_ready = ($urandom_range(99) < p_mready);
        m_data_ready = ($urandom_range(99) < p_dready);
    endtask

    task automatic evaluate();
        int           pk, h;
        bit           grant, exp_dv, pop;
        logic [N-1:0] exp_sr, exp_dr;
        if (rst) begin
            model_reset();
            return;
        end
        pk = -1;
        if (!m_held || m_meta_ready) begin
            for (int k = 1; k <= N; k++) begin
                int idx = (m_rr + k) % N;
                if (pk < 0 && s_meta_valid[idx]) pk = idx;
            end
        end
        grant  = (pk >= 0) && !(s_meta_payload[pk] && m_fifo.size() == DEPTH);
        exp_sr = '0;
        if (grant) exp_sr[pk] = 1'b1;
        check("s_meta_ready", 64'(s_meta_ready), 64'(exp_sr));
        check("m_meta_valid", 64'(m_meta_valid), 64'(m_held));
        if (m_held) check("m_meta_data", 64'(m_meta_data), 64'(m_word));
        check("order_full", 64'(order_full), 64'(m_fifo.size() == DEPTH));

        exp_dr = '0;
        exp_dv = 1'b0;
        h      = 0;
        if (m_fifo.size() > 0) begin
            h         = m_fifo[0];
            exp_dv    = s_data_valid[h];
            exp_dr[h] = m_data_ready;
        end
        check("m_data_valid", 64'(m_data_valid), 64'(exp_dv));
        check("s_data_ready", 64'(s_data_ready), 64'(exp_dr));
        pop = 1'b0;
        if (exp_dv) begin
            check("m_data_data", 64'(m_data_data), 64'(dq[h][0].d));
            check("m_data_keep", 64'(m_data_keep), 64'(dq[h][0].k));
            check("m_data_last", 64'(m_data_last), 64'(dq[h][0].last));
            if (m_data_ready) begin
                beats_seen++;
                pop = dq[h][0].last;
                dq[h].delete(0);
            end
        end
        if (pop) begin
            m_fifo.delete(0);
            m_pkt_cnt[h]++;
        end
        if (grant) begin
            m_held = 1'b1;
            m_word = cq[pk][0].meta;
            m_rr   = pk;
            m_cmd_cnt[pk]++;
            if (cq[pk][0].pay) m_fifo.push_back(pk);
            cq[pk].delete(0);
        end else if (m_meta_ready) begin
            m_held = 1'b0;
        end
    endtask

    task automatic cycle(input bit r);
        @(posedge clk);
        #1;
        rst = r;
        drive();
        @(negedge clk);
        evaluate();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (!idle() && n < budget) begin
            cycle(1'b0);
            n++;
        end
        check("drain_done", 64'(idle()), 64'd1);
    endtask

    task automatic set_knobs(input int pm, input int pd, input int pmr, input int pdr);
        p_meta   = pm;
        p_data   = pd;
        p_mready = pmr;
        p_dready = pdr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rst            = 1'b1;
        s_meta_valid   = '0;
        s_meta_payload = '0;
        s_meta_data    = '0;
        s_data_valid   = '0;
        s_data_last    = '0;
        s_data_data    = '0;
        s_data_keep    = '0;
        m_meta_ready   = 1'b0;
        m_data_ready   = 1'b0;
        data_mask      = '1;
        seq            = 0;
        beats_seen     = 0;
        set_knobs(100, 100, 100, 100);
        model_reset();

        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);
        check("reset_m_meta_valid", 64'(m_meta_valid), 64'd0);
        check("reset_order_full", 64'(order_full), 64'd0);

        // Round robin with continuous no-payload traffic.
        for (int r = 0; r < N; r++) for (int j = 0; j < 6; j++) gen(r, 1'b0, 0);
        drain(100);

        // Payload order: req0 data waits behind req2's earlier command.
        data_mask = 4'b0001;
        gen(2, 1'b1, 3);
        cycle(1'b0);
        gen(0, 1'b1, 1);
        for (int j = 0; j < 4; j++) cycle(1'b0);
        check("order_req0_stalled", 64'(s_data_ready[0]), 64'd0);
        data_mask = '1;
        drain(100);

        // Randomized mixed traffic with random backpressure.
        set_knobs(70, 70, 60, 60);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(99) < 35)
                gen(int'($urandom_range(N - 1)), 1'($urandom), int'($urandom_range(1, 4)));
            cycle(1'b0);
        end
        drain(3000);

        // Order FIFO full: payload commands blocked, no-payload ones pass.
        set_knobs(100, 100, 100, 100);
        data_mask = '0;
        for (int j = 0; j < DEPTH + 1; j++) gen(0, 1'b1, 1);
        gen(1, 1'b0, 0);
        for (int j = 0; j < 20; j++) cycle(1'b0);
        check("full_flag", 64'(order_full), 64'd1);
        gen(2, 1'b0, 0);
        for (int j = 0; j < 3; j++) cycle(1'b0);
        data_mask = '1;
        drain(200);

        // Meta backpressure.
        for (int r = 0; r < N; r++) gen(r, 1'b0, 0);
        set_knobs(100, 100, 100, 100);
        cycle(1'b0);
        p_mready = 0;
        for (int j = 0; j < 5; j++) cycle(1'b0);
        p_mready = 100;
        drain(100);

        // Reset during beat 2 of 4.
        gen(1, 1'b1, 4);
        b0 = beats_seen;
        for (int j = 0; j < 20 && beats_seen - b0 < 1; j++) cycle(1'b0);
        cycle(1'b1);
        cycle(1'b0);
        check("rst_m_meta_valid", 64'(m_meta_valid), 64'd0);
        check("rst_m_data_valid", 64'(m_data_valid), 64'd0);
        check("rst_s_data_ready", 64'(s_data_ready), 64'd0);
        check("rst_order_full", 64'(order_full), 64'd0);
        for (int r = 0; r < N; r++) gen(r, 1'b0, 0);
        cycle(1'b0);
        check("rst_first_grant", 64'(s_meta_ready), 64'd1);
        drain(100);

        // Statistics scenario from a clean reset.
        cycle(1'b1);
        for (int j = 0; j < 3; j++) gen(1, 1'b1, 1);
        drain(100);
`ifdef ROCE_TX_ARB_STATS_EN
        check("stat_cmd_req1", 64'(stat_cmd_count[32 +: 32]), 64'd3);
        check("stat_pkt_req1", 64'(stat_pkt_count[32 +: 32]), 64'd3);
        for (int i = 0; i < N; i++) begin
            check("stat_cmd_count", 64'(stat_cmd_count[i*32 +: 32]), 64'(m_cmd_cnt[i]));
            check("stat_pkt_count", 64'(stat_pkt_count[i*32 +: 32]), 64'(m_pkt_cnt[i]));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
